// File: rtl/armleocpu_tlb_walker_pkg.sv
// rtl/armleocpu_tlb_walker_pkg.sv - shared walker states, TLB command codes and PTE bit positions
package armleocpu_tlb_walker_pkg;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_IDLE      = 3'd1,
    ST_LOOKUP    = 3'd2,
    ST_WALK_REQ  = 3'd3,
    ST_WALK_WAIT = 3'd4,
    ST_REFILL    = 3'd5
  } walker_state_t;

  localparam logic [1:0] TLB_CMD_NONE           = 2'd0;
  localparam logic [1:0] TLB_CMD_RESOLVE        = 2'd1;
  localparam logic [1:0] TLB_CMD_NEW_ENTRY      = 2'd2;
  localparam logic [1:0] TLB_CMD_INVALIDATE_ALL = 2'd3;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;

endpackage

// File: rtl/armleocpu_pte_decode.sv
// rtl/armleocpu_pte_decode.sv - combinational Sv32 PTE classification for one walk level
module armleocpu_pte_decode
  import armleocpu_tlb_walker_pkg::*;
(
  input  logic [31:0] pte_i,
  input  logic        level_i,
  input  logic [19:0] vpn_i,
  output logic        fault_o,
  output logic        leaf_o,
  output logic [21:0] next_base_o,
  output logic [21:0] ptag_o,
  output logic [7:0]  metadata_o
);

  // RSW bits carry no meaning for translation.
  logic unused_rsw;
  assign unused_rsw = ^pte_i[9:8];

  always_comb begin
    leaf_o      = pte_i[PTE_R] | pte_i[PTE_X];
    next_base_o = pte_i[31:10];
    metadata_o  = pte_i[7:0];
    // A megapage keeps the low VPN bits as the low part of the physical page.
    ptag_o      = level_i ? {pte_i[31:20], vpn_i[9:0]} : pte_i[31:10];
    fault_o     = !pte_i[PTE_V]
               || (!pte_i[PTE_R] && pte_i[PTE_W])
               || (leaf_o && level_i && (pte_i[19:10] != '0))
               || (!leaf_o && !level_i);
  end

endmodule

// File: rtl/armleocpu_tlb_walker.sv
// rtl/armleocpu_tlb_walker.sv - sequences one TLB for a single requester and walks Sv32 tables on miss
module armleocpu_tlb_walker
  import armleocpu_tlb_walker_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [19:0] req_vpn,
  input  logic [21:0] satp_ppn,
  output logic        rsp_valid,
  output logic        rsp_pagefault,
  output logic        rsp_accessfault,
  output logic [7:0]  rsp_metadata,
  output logic [21:0] rsp_ptag,
  input  logic        flush_valid,
  output logic        flush_ready,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [33:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_error,
  output logic [1:0]  tlb_cmd,
  output logic [19:0] tlb_vaddr,
  input  logic        tlb_hit,
  input  logic [7:0]  tlb_metadata,
  input  logic [21:0] tlb_ptag,
  output logic [7:0]  tlb_new_metadata,
  output logic [21:0] tlb_new_ptag
);

  walker_state_t state_q, state_d;
  logic [19:0]   vpn_q, vpn_d;
  logic [21:0]   base_q, base_d;
  logic          level_q, level_d;
  logic [7:0]    meta_q, meta_d;
  logic [21:0]   ptag_q, ptag_d;

  logic          dec_fault;
  logic          dec_leaf;
  logic [21:0]   dec_next_base;
  logic [21:0]   dec_ptag;
  logic [7:0]    dec_metadata;

  armleocpu_pte_decode u_pte_decode (
    .pte_i       (mem_rsp_data),
    .level_i     (level_q),
    .vpn_i       (vpn_q),
    .fault_o     (dec_fault),
    .leaf_o      (dec_leaf),
    .next_base_o (dec_next_base),
    .ptag_o      (dec_ptag),
    .metadata_o  (dec_metadata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      vpn_q   <= '0;
      base_q  <= '0;
      level_q <= 1'b0;
      meta_q  <= '0;
      ptag_q  <= '0;
    end else begin
      state_q <= state_d;
      vpn_q   <= vpn_d;
      base_q  <= base_d;
      level_q <= level_d;
      meta_q  <= meta_d;
      ptag_q  <= ptag_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    vpn_d            = vpn_q;
    base_d           = base_q;
    level_d          = level_q;
    meta_d           = meta_q;
    ptag_d           = ptag_q;
    req_ready        = 1'b0;
    flush_ready      = 1'b0;
    rsp_valid        = 1'b0;
    rsp_pagefault    = 1'b0;
    rsp_accessfault  = 1'b0;
    rsp_metadata     = '0;
    rsp_ptag         = '0;
    mem_req_valid    = 1'b0;
    mem_req_addr     = {base_q, (level_q ? vpn_q[19:10] : vpn_q[9:0]), 2'b00};
    tlb_cmd          = TLB_CMD_NONE;
    tlb_vaddr        = vpn_q;
    tlb_new_metadata = meta_q;
    tlb_new_ptag     = ptag_q;

    case (state_q)
      ST_INIT: begin
        tlb_cmd = TLB_CMD_INVALIDATE_ALL;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        // Flush wins so an invalidate is never starved by a busy requester.
        if (flush_valid) begin
          tlb_cmd     = TLB_CMD_INVALIDATE_ALL;
          flush_ready = 1'b1;
        end else begin
          req_ready = 1'b1;
          if (req_valid) begin
            tlb_cmd   = TLB_CMD_RESOLVE;
            tlb_vaddr = req_vpn;
            vpn_d     = req_vpn;
            base_d    = satp_ppn;
            state_d   = ST_LOOKUP;
          end
        end
      end
      ST_LOOKUP: begin
        if (tlb_hit) begin
          rsp_valid    = 1'b1;
          rsp_metadata = tlb_metadata;
          rsp_ptag     = tlb_ptag;
          state_d      = ST_IDLE;
        end else begin
          level_d = 1'b1;
          state_d = ST_WALK_REQ;
        end
      end
      ST_WALK_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = ST_WALK_WAIT;
        end
      end
      ST_WALK_WAIT: begin
        if (mem_rsp_valid) begin
          if (mem_rsp_error) begin
            rsp_valid       = 1'b1;
            rsp_accessfault = 1'b1;
            state_d         = ST_IDLE;
          end else if (dec_fault) begin
            rsp_valid     = 1'b1;
            rsp_pagefault = 1'b1;
            state_d       = ST_IDLE;
          end else if (dec_leaf) begin
            meta_d  = dec_metadata;
            ptag_d  = dec_ptag;
            state_d = ST_REFILL;
          end else begin
            base_d  = dec_next_base;
            level_d = 1'b0;
            state_d = ST_WALK_REQ;
          end
        end
      end
      ST_REFILL: begin
        tlb_cmd      = TLB_CMD_NEW_ENTRY;
        rsp_valid    = 1'b1;
        rsp_metadata = meta_q;
        rsp_ptag     = ptag_q;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_armleocpu_tlb_walker.sv
// tb/tb_armleocpu_tlb_walker.sv - scoreboard bench with behavioural TLB and PTE memory models
module tb_armleocpu_tlb_walker;

  localparam logic [1:0] CMD_NONE    = 2'd0;
  localparam logic [1:0] CMD_RESOLVE = 2'd1;
  localparam logic [1:0] CMD_NEW     = 2'd2;
  localparam logic [1:0] CMD_INV     = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [19:0] req_vpn = '0;
  logic [21:0] satp_ppn = '0;
  logic        rsp_valid, rsp_pagefault, rsp_accessfault;
  logic [7:0]  rsp_metadata;
  logic [21:0] rsp_ptag;
  logic        flush_valid = 1'b0;
  logic        flush_ready;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [33:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        mem_rsp_error = 1'b0;
  logic [1:0]  tlb_cmd;
  logic [19:0] tlb_vaddr;
  logic        tlb_hit = 1'b0;
  logic [7:0]  tlb_metadata = '0;
  logic [21:0] tlb_ptag = '0;
  logic [7:0]  tlb_new_metadata;
  logic [21:0] tlb_new_ptag;

  always #5 clk = ~clk;

  armleocpu_tlb_walker dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn), .satp_ppn(satp_ppn),
    .rsp_valid(rsp_valid), .rsp_pagefault(rsp_pagefault), .rsp_accessfault(rsp_accessfault),
    .rsp_metadata(rsp_metadata), .rsp_ptag(rsp_ptag),
    .flush_valid(flush_valid), .flush_ready(flush_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_error(mem_rsp_error),
    .tlb_cmd(tlb_cmd), .tlb_vaddr(tlb_vaddr), .tlb_hit(tlb_hit),
    .tlb_metadata(tlb_metadata), .tlb_ptag(tlb_ptag),
    .tlb_new_metadata(tlb_new_metadata), .tlb_new_ptag(tlb_new_ptag)
  );

  typedef struct packed {
    logic        pf;
    logic        af;
    logic [7:0]  meta;
    logic [21:0] ptag;
  } rsp_t;

  typedef struct packed {
    rsp_t r;
    int   lat;
  } exp_t;

  typedef struct {
    logic [19:0] vpn;
    logic [21:0] satp;
    exp_t        e;
    int          n_mem;
    int          n_new;
    logic [33:0] a0;
    logic [33:0] a1;
  } case_t;

  exp_t        exp_q[$];
  logic [33:0] mem_log[$];
  logic [29:0] tlb_ent [logic [19:0]];
  logic [31:0] mem [logic [33:0]];
  logic [33:0] err_addr = '0;
  logic        err_en = 1'b0;
  int          mem_lat = 0;
  int          new_cnt = 0;
  logic [19:0] last_new_va = '0;
  logic [29:0] last_new = '0;
  int          pre_seq = 0;
  logic [19:0] pre_vpn = '0;
  logic [29:0] pre_val = '0;

  int   n_cmp = 0;
  int   n_fail = 0;
  rsp_t act;
  int   act_lat;
  int   act_wait;

  // TLB and memory models: sample DUT outputs at the edge, respond 1 time unit later.
  always begin : models
    logic [1:0]  c;
    logic [19:0] va;
    logic [7:0]  nm;
    logic [21:0] np;
    logic        acc;
    logic [33:0] acc_addr;
    bit          pend;
    logic [33:0] pend_addr;
    int          wait_left;
    int          pre_seen;
    pend = 0; pend_addr = '0; wait_left = 0; pre_seen = 0;
    forever begin
      @(posedge clk);
      c = tlb_cmd; va = tlb_vaddr; nm = tlb_new_metadata; np = tlb_new_ptag;
      acc = mem_req_valid && mem_req_ready; acc_addr = mem_req_addr;
      #1;
      if (pre_seq != pre_seen) begin
        tlb_ent[pre_vpn] = pre_val;
        pre_seen = pre_seq;
      end
      if (c == CMD_RESOLVE) begin
        tlb_hit = tlb_ent.exists(va);
        {tlb_metadata, tlb_ptag} = tlb_hit ? tlb_ent[va] : 30'h0;
      end else if (c == CMD_NEW) begin
        tlb_ent[va] = {nm, np};
        new_cnt++;
        last_new_va = va;
        last_new = {nm, np};
      end else if (c == CMD_INV) begin
        tlb_ent.delete();
      end
      mem_rsp_valid = 1'b0; mem_rsp_error = 1'b0; mem_rsp_data = '0;
      if (acc) begin
        pend = 1; pend_addr = acc_addr; wait_left = mem_lat;
        mem_log.push_back(acc_addr);
      end
      if (pend) begin
        if (wait_left == 0) begin
          mem_rsp_valid = 1'b1;
          if (err_en && pend_addr == err_addr) begin
            mem_rsp_error = 1'b1;
            mem_rsp_data = 32'h0000000F;
          end else begin
            mem_rsp_data = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
          end
          pend = 0;
        end else begin
          wait_left--;
        end
      end
    end
  end

  task automatic wait_rsp();
    int n;
    n = 1;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    act_lat = rsp_valid ? n : -1;
    act = {rsp_pagefault, rsp_accessfault, rsp_metadata, rsp_ptag};
  endtask

  task automatic issue(input logic [19:0] vpn, input logic [21:0] satp);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_vpn = vpn; satp_ppn = satp;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    act_wait = n;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({tlb_cmd, req_ready, flush_ready, rsp_valid, rsp_pagefault, rsp_accessfault, mem_req_valid} !== {CMD_INV, 6'b0}
        || rsp_metadata !== 8'h0 || rsp_ptag !== 22'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: cmd=%0d rr=%b fr=%b rv=%b mrv=%b meta=%h ptag=%h, want cmd=3 and all zero",
               tlb_cmd, req_ready, flush_ready, rsp_valid, mem_req_valid, rsp_metadata, rsp_ptag);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (tlb_cmd !== CMD_INV || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init_cycle: cmd=%0d req_ready=%b, want cmd=3 req_ready=0", tlb_cmd, req_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (tlb_cmd !== CMD_NONE || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_idle: cmd=%0d req_ready=%b, want cmd=0 req_ready=1", tlb_cmd, req_ready);
    end
  endtask

  task automatic test_hit();
    exp_t e;
    int   m0;
    pre_vpn = 20'h12345; pre_val = {8'hCF, 22'h3ABCD}; pre_seq++;
    @(posedge clk); #2;
    m0 = mem_log.size();
    exp_q.push_back('{'{1'b0, 1'b0, 8'hCF, 22'h3ABCD}, 1});
    issue(20'h12345, 22'h00100);
    e = exp_q.pop_front();
    n_cmp++;
    if (act !== e.r || act_lat != e.lat) begin
      n_fail++;
      $display("FAIL hit_rsp: got %h lat %0d, want %h lat %0d", act, act_lat, e.r, e.lat);
    end
    n_cmp++;
    if (mem_log.size() != m0) begin
      n_fail++;
      $display("FAIL hit_no_mem: got %0d mem requests, want 0", mem_log.size() - m0);
    end
  endtask

  task automatic test_walk();
    case_t c[5];
    exp_t  e;
    int    m0, w0;
    mem[34'h0_0010_0004] = 32'h00200001;
    mem[34'h0_0080_000C] = 32'h12345CCF;
    mem[34'h0_0030_0000] = 32'h4000000F;
    mem[34'h0_0030_0004] = 32'h4000040F;
    mem[34'h0_0050_0008] = 32'h00180001;
    err_addr = 34'h0_0070_000C; err_en = 1'b1;
    c[0] = '{20'h00403, 22'h100, '{'{1'b0, 1'b0, 8'hCF, 22'h048D17}, 6}, 2, 1, 34'h0_0010_0004, 34'h0_0080_000C};
    c[1] = '{20'h00155, 22'h300, '{'{1'b0, 1'b0, 8'h0F, 22'h100155}, 4}, 1, 1, 34'h0_0030_0000, 34'h0};
    c[2] = '{20'h00556, 22'h300, '{'{1'b1, 1'b0, 8'h00, 22'h0}, 3}, 1, 0, 34'h0_0030_0004, 34'h0};
    c[3] = '{20'h00801, 22'h500, '{'{1'b1, 1'b0, 8'h00, 22'h0}, 5}, 2, 0, 34'h0_0050_0008, 34'h0_0060_0004};
    c[4] = '{20'h00C00, 22'h700, '{'{1'b0, 1'b1, 8'h00, 22'h0}, 3}, 1, 0, 34'h0_0070_000C, 34'h0};
    for (int i = 0; i < 5; i++) begin
      m0 = mem_log.size(); w0 = new_cnt;
      exp_q.push_back(c[i].e);
      issue(c[i].vpn, c[i].satp);
      @(posedge clk); #2;
      e = exp_q.pop_front();
      n_cmp++;
      if (act !== e.r || act_lat != e.lat) begin
        n_fail++;
        $display("FAIL walk%0d_rsp: got %h lat %0d, want %h lat %0d", i, act, act_lat, e.r, e.lat);
      end
      n_cmp++;
      if (mem_log.size() - m0 != c[i].n_mem || new_cnt - w0 != c[i].n_new) begin
        n_fail++;
        $display("FAIL walk%0d_counts: got mem %0d new %0d, want mem %0d new %0d",
                 i, mem_log.size() - m0, new_cnt - w0, c[i].n_mem, c[i].n_new);
      end else begin
        n_cmp++;
        if (mem_log[m0] !== c[i].a0 || (c[i].n_mem == 2 && mem_log[m0 + 1] !== c[i].a1)) begin
          n_fail++;
          $display("FAIL walk%0d_addr: got %h %h, want %h %h", i, mem_log[m0],
                   (c[i].n_mem == 2) ? mem_log[m0 + 1] : 34'h0, c[i].a0, c[i].a1);
        end
        if (c[i].n_new == 1) begin
          n_cmp++;
          if (last_new_va !== c[i].vpn || last_new !== {e.r.meta, e.r.ptag}) begin
            n_fail++;
            $display("FAIL walk%0d_refill: got va %h entry %h, want va %h entry %h",
                     i, last_new_va, last_new, c[i].vpn, {e.r.meta, e.r.ptag});
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_q.push_back('{'{1'b0, 1'b0, 8'hCF, 22'h048D17}, 1});
    exp_q.push_back('{'{1'b0, 1'b0, 8'h0F, 22'h100155}, 1});
    for (int i = 0; i < 2; i++) begin
      issue(i == 0 ? 20'h00403 : 20'h00155, 22'h3FFFFF);
      e = exp_q.pop_front();
      n_cmp++;
      if (act !== e.r || act_lat != e.lat || (i == 1 && act_wait != 0)) begin
        n_fail++;
        $display("FAIL b2b%0d: got %h lat %0d wait %0d, want %h lat %0d wait 0", i, act, act_lat, act_wait, e.r, e.lat);
      end
    end
  endtask

  task automatic test_flush();
    exp_t e;
    @(posedge clk); #1;
    flush_valid = 1'b1; req_valid = 1'b1; req_vpn = 20'h00403; satp_ppn = 22'h100;
    @(negedge clk);
    n_cmp++;
    if (flush_ready !== 1'b1 || req_ready !== 1'b0 || tlb_cmd !== CMD_INV) begin
      n_fail++;
      $display("FAIL flush_priority: fr=%b rr=%b cmd=%0d, want fr=1 rr=0 cmd=3", flush_ready, req_ready, tlb_cmd);
    end
    @(posedge clk); #1;
    flush_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || tlb_cmd !== CMD_RESOLVE || flush_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_then_accept: rr=%b cmd=%0d fr=%b, want rr=1 cmd=1 fr=0", req_ready, tlb_cmd, flush_ready);
    end
    exp_q.push_back('{'{1'b0, 1'b0, 8'hCF, 22'h048D17}, 6});
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp();
    e = exp_q.pop_front();
    n_cmp++;
    if (act !== e.r || act_lat != e.lat) begin
      n_fail++;
      $display("FAIL flush_rewalk: got %h lat %0d, want %h lat %0d", act, act_lat, e.r, e.lat);
    end
  endtask

  task automatic test_reset_mid_walk();
    exp_t e;
    int   m0, n;
    mem_lat = 3;
    m0 = mem_log.size();
    @(posedge clk); #1;
    req_valid = 1'b1; req_vpn = 20'h00404; satp_ppn = 22'h100;
    n = 0;
    @(negedge clk);
    while (mem_log.size() == m0 && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (mem_log.size() == m0 || tlb_cmd !== CMD_INV || req_ready !== 1'b0 || rsp_valid !== 1'b0
        || mem_req_valid !== 1'b0 || rsp_metadata !== 8'h0 || rsp_ptag !== 22'h0) begin
      n_fail++;
      $display("FAIL async_reset: reqs=%0d cmd=%0d rr=%b rv=%b mrv=%b, want reqs>0 cmd=3 rr=0 rv=0 mrv=0",
               mem_log.size() - m0, tlb_cmd, req_ready, rsp_valid, mem_req_valid);
    end
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    mem_lat = 0;
    m0 = mem_log.size();
    exp_q.push_back('{'{1'b0, 1'b0, 8'h0F, 22'h100155}, 4});
    issue(20'h00155, 22'h300);
    e = exp_q.pop_front();
    n_cmp++;
    if (act !== e.r || act_lat != e.lat || mem_log.size() - m0 != 1) begin
      n_fail++;
      $display("FAIL post_reset_walk: got %h lat %0d reqs %0d, want %h lat %0d reqs 1",
               act, act_lat, mem_log.size() - m0, e.r, e.lat);
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_walk();
    test_back_to_back();
    test_flush();
    test_reset_mid_walk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
